board_write_arbiter: RTL and testbench
======================================

Name: board_write_arbiter

Overview:
- Shares the single Board_RAM write port (wren / wraddress / data) between N sprite movers: Pac-Man plus the four ghosts.
- Each mover issues one move request. The request carries the old cell, the tile to restore there, the new cell, and the sprite tile to draw.
- The arbiter grants requests round-robin. For each grant it performs a two-write sequence (clear old, then draw new) and acknowledges completion.
- It replaces the inline idle/clear_old/draw_pac/update FSM in the top level. Movers update their own location registers on ack.

Parameters:
- N_REQ, 5, number of requesters (index 0 = Pac-Man, 1..4 = ghosts).
- ADDR_W, 10, Board_RAM address width.
- DATA_W, 4, block-type width.
- BOARD_CELLS, 768, number of valid cells (32 x 24); addresses >= this are illegal.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester move request; level, held until ack.
- old_addr  in  N_REQ*ADDR_W  packed; slice i = requester i's current cell.
- old_tile  in  N_REQ*DATA_W  packed; tile written back to old cell.
- new_addr  in  N_REQ*ADDR_W  packed; destination cell.
- new_tile  in  N_REQ*DATA_W  packed; sprite tile for destination.
- ack  out  N_REQ  one-cycle pulse, one-hot, on completion of requester i's transaction.
- busy  out  1  high whenever state != IDLE.
- grant_id  out  3  index of the granted requester; valid while busy.
- wren  out  1  Board_RAM write enable.
- write_addr  out  ADDR_W  Board_RAM write address.
- write_data  out  DATA_W  Board_RAM write data.
- err  out  1  sticky; set when an out-of-range address is suppressed.

Behaviour:
- States: IDLE, CLEAR, DRAW, DONE. All outputs are registered or decoded only from the state and latched registers.
- Reset (any state, including mid-transaction):
  - state = IDLE.
  - Outputs: wren = 0, write_addr = 0, write_data = 0, ack = 0, busy = 0, grant_id = 0, err = 0.
  - rr_ptr = 0.
  - An interrupted transaction is abandoned with no ack.
- IDLE: if any req bit is set, select the first set bit scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - Latch that requester's old_addr, old_tile, new_addr, new_tile and set grant_id.
  - Next state is CLEAR, or DRAW directly if old_addr == new_addr (skip clear).
  - Operands are sampled only at grant; later changes on the inputs are ignored.
- CLEAR (1 cycle): wren = 1, write_addr = latched old_addr, write_data = latched old_tile. Next state DRAW.
- DRAW (1 cycle): wren = 1, write_addr = latched new_addr, write_data = latched new_tile. Next state DONE.
- DONE (1 cycle):
  - wren = 0, ack[grant_id] = 1.
  - rr_ptr = grant_id + 1, wrapping N_REQ-1 -> 0.
  - Next state IDLE.
- Latency: req seen high at edge k gives CLEAR at cycle k+1, DRAW at k+2, ack at k+3. With skip, ack at k+2. Minimum spacing between grants is 4 cycles (3 with skip).
- Requester handshake: a requester drops req on the same edge that samples ack high. Because rr_ptr advances past the completed requester, a still-high req loses to any other pending requester.
- Out-of-range address (>= BOARD_CELLS) in CLEAR or DRAW:
  - wren is held 0 for that phase and err is set.
  - The sequence still completes and ack still fires, so no deadlock occurs.
- Simultaneous requests: exactly one grant per transaction; the others wait. There is no starvation: worst-case wait is N_REQ-1 transactions.
- req bits for indices >= N_REQ do not exist; grant_id never exceeds N_REQ-1.

Optional Feature:
- Macro PAC_PRIORITY_EN.
- Defined: in IDLE, if req[0] is set it is granted regardless of rr_ptr. Ghosts are round-robin among 1..N_REQ-1 only, and rr_ptr is not updated by Pac-Man grants.
- Undefined: pure round-robin over all N_REQ requesters as described above.

Test Plan:
- Single request: req[0] = 1 with old 10'd40, old_tile 4'd0, new 10'd41, new_tile 4'd3. Expected: cycle+1 wren = 1, addr 40, data 0; cycle+2 wren = 1, addr 41, data 3; cycle+3 ack = 5'b00001, wren = 0.
- Skip clear: req[2] with old = new = 10'd100, new_tile 4'd5. Expected: exactly one write (100 <- 5), then ack[2] at cycle+2.
- Contention: all five req high together from reset, each dropping req after its ack. Expected: grants in order 0, 1, 2, 3, 4, each 4 cycles apart. Repeat with req held continuously; grant order must rotate 0..4,0 with no repeat while others pend.
- Range error: req[1] with new_addr 10'd800. Expected: CLEAR write happens, DRAW has wren = 0, err = 1 (sticky), ack[1] still pulses.
- Reset mid-operation: reset asserted during DRAW. Expected: next cycle state IDLE, wren = 0, no ack, rr_ptr = 0; a subsequent req[3] is serviced normally.
- With PAC_PRIORITY_EN: req[0] and req[2] high together, and req[0] re-asserted as soon as its ack completes. Expected: 0 granted ahead of 2 in every contested cycle.

Source files
------------

// File: rtl/board_write_arbiter.sv
// Round-robin owner of the Board_RAM write port: clear old cell, draw new cell, pulse ack. PAC_PRIORITY_EN lets Pac-Man pre-empt the ghost rotation.
// Latency: grant edge -> CLEAR next cycle, DRAW after, ack after that (one cycle less on skip); requesters hold req until ack.
module board_write_arbiter #(
  parameter int N_REQ       = 5,
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 4,
  parameter int BOARD_CELLS = 768
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*ADDR_W-1:0]  old_addr,
  input  logic [N_REQ*DATA_W-1:0]  old_tile,
  input  logic [N_REQ*ADDR_W-1:0]  new_addr,
  input  logic [N_REQ*DATA_W-1:0]  new_tile,
  output logic [N_REQ-1:0]         ack,
  output logic                     busy,
  output logic [2:0]               grant_id,
  output logic                     wren,
  output logic [ADDR_W-1:0]        write_addr,
  output logic [DATA_W-1:0]        write_data,
  output logic                     err
);

  typedef enum logic [1:0] {IDLE, CLEAR, DRAW, DONE} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] tile;
  } cell_t;

  localparam logic [3:0]        NQ    = 4'(N_REQ);
  localparam logic [2:0]        LAST  = 3'(N_REQ - 1);
  localparam logic [ADDR_W:0]   CELLS = (ADDR_W + 1)'(BOARD_CELLS);

  state_t     state;
  logic [2:0] rr_ptr;
  cell_t      pend_dat;

  cell_t      old_c [N_REQ];
  cell_t      new_c [N_REQ];

  logic       sel_vld;
  logic [2:0] sel_id;
  logic       skip;
  cell_t      first_cell;
  logic [2:0] rr_nxt;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign old_c[g] = {old_addr[g*ADDR_W +: ADDR_W], old_tile[g*DATA_W +: DATA_W]};
    assign new_c[g] = {new_addr[g*ADDR_W +: ADDR_W], new_tile[g*DATA_W +: DATA_W]};
  end

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < CELLS);
  endfunction

`ifdef PAC_PRIORITY_EN
  // Ghosts rotate over 1..N_REQ-1; rr_ptr == 0 just means "start at ghost 1".
  logic [3:0] base;
  logic [3:0] j;
  always_comb begin
    sel_vld = 1'b0;
    sel_id  = 3'd0;
    base    = (rr_ptr == 3'd0) ? 4'd1 : {1'b0, rr_ptr};
    j       = 4'd0;
    for (int k = N_REQ - 2; k >= 0; k--) begin
      j = base + 4'(k);
      if (j >= NQ) j = j - (NQ - 4'd1);
      if (req[j[2:0]]) begin
        sel_vld = 1'b1;
        sel_id  = j[2:0];
      end
    end
    if (req[0]) begin
      sel_vld = 1'b1;
      sel_id  = 3'd0;
    end
  end
`else
  // Descending scan so the candidate closest to rr_ptr is the last one written.
  logic [3:0] j;
  always_comb begin
    sel_vld = 1'b0;
    sel_id  = 3'd0;
    j       = 4'd0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = {1'b0, rr_ptr} + 4'(k);
      if (j >= NQ) j = j - NQ;
      if (req[j[2:0]]) begin
        sel_vld = 1'b1;
        sel_id  = j[2:0];
      end
    end
  end
`endif

  always_comb begin
    skip       = (old_c[sel_id].addr == new_c[sel_id].addr);
    first_cell = skip ? new_c[sel_id] : old_c[sel_id];
    rr_nxt     = (grant_id == LAST) ? 3'd0 : grant_id + 3'd1;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= 3'd0;
      pend_dat   <= '0;
      grant_id   <= 3'd0;
      wren       <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      ack        <= '0;
      err        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (sel_vld) begin
            grant_id   <= sel_id;
            pend_dat   <= new_c[sel_id];
            state      <= skip ? DRAW : CLEAR;
            write_addr <= first_cell.addr;
            write_data <= first_cell.tile;
            wren       <= in_range(first_cell.addr);
            if (!in_range(first_cell.addr)) err <= 1'b1;
          end
        end
        CLEAR: begin
          state      <= DRAW;
          write_addr <= pend_dat.addr;
          write_data <= pend_dat.tile;
          wren       <= in_range(pend_dat.addr);
          if (!in_range(pend_dat.addr)) err <= 1'b1;
        end
        DRAW: begin
          state <= DONE;
          wren  <= 1'b0;
          for (int i = 0; i < N_REQ; i++) ack[i] <= (grant_id == 3'(i));
        end
        DONE: begin
          state <= IDLE;
          ack   <= '0;
`ifdef PAC_PRIORITY_EN
          if (grant_id != 3'd0) rr_ptr <= rr_nxt;
`else
          rr_ptr <= rr_nxt;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert ($onehot0(ack));
      assert (grant_id <= LAST);
    end
  end

endmodule

// File: tb/tb_board_write_arbiter.sv
// Randomized bench for board_write_arbiter against a transaction-level expected-output schedule.
module tb_board_write_arbiter;
  localparam int N = 5;

  logic        clk;
  logic        reset;
  logic [4:0]  req;
  logic [49:0] old_addr, new_addr;
  logic [19:0] old_tile, new_tile;
  logic [4:0]  ack;
  logic        busy;
  logic [2:0]  grant_id;
  logic        wren;
  logic [9:0]  write_addr;
  logic [3:0]  write_data;
  logic        err;

  board_write_arbiter dut (
    .clk(clk), .reset(reset), .req(req),
    .old_addr(old_addr), .old_tile(old_tile), .new_addr(new_addr), .new_tile(new_tile),
    .ack(ack), .busy(busy), .grant_id(grant_id), .wren(wren),
    .write_addr(write_addr), .write_data(write_data), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       wren;
    logic [9:0] addr;
    logic [3:0] data;
    logic [4:0] ack;
    logic       busy;
    logic [2:0] gid;
    logic       err;
    int         ph;
    logic       rst;
  } exp_t;

  logic [9:0] oa [N];
  logic [9:0] na [N];
  logic [3:0] ot [N];
  logic [3:0] nt [N];
  logic [4:0] hold;
  int         rate;
  bit         rand_rst, mid_arm, inj;
  int         n_chk, n_fail;
  exp_t       exp_q [$];
  exp_t       cur;
  int         rr_m, gp_m, granted;
  logic       err_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      old_addr[i*10 +: 10] = oa[i];
      new_addr[i*10 +: 10] = na[i];
      old_tile[i*4 +: 4]   = ot[i];
      new_tile[i*4 +: 4]   = nt[i];
    end
  endtask

  function automatic logic legal(input logic [9:0] a);
    return a < 10'd768;
  endfunction

  function automatic logic [9:0] rnd_addr();
    if ($urandom_range(0, 9) == 0) return 10'($urandom_range(768, 1023));
    return 10'($urandom_range(0, 767));
  endfunction

  task automatic rand_ops(input int i);
    oa[i] = rnd_addr();
    na[i] = ($urandom_range(0, 4) == 0) ? oa[i] : rnd_addr();
    ot[i] = 4'($urandom_range(0, 15));
    nt[i] = 4'($urandom_range(0, 15));
  endtask

  // Winner by the arbitration rule, with the pointer kept as plain integers.
  function automatic int pick();
    int w;
    w = -1;
`ifdef PAC_PRIORITY_EN
    if (req[0]) w = 0;
    else
      for (int k = 0; k < N - 1; k++)
        if (w < 0 && req[(gp_m - 1 + k) % (N - 1) + 1]) w = (gp_m - 1 + k) % (N - 1) + 1;
    if (w != 0) gp_m = w % (N - 1) + 1;
`else
    for (int k = 0; k < N; k++)
      if (w < 0 && req[(rr_m + k) % N]) w = (rr_m + k) % N;
    rr_m = (w + 1) % N;
`endif
    return w;
  endfunction

  function automatic exp_t idle_entry();
    exp_t e;
    e = '{wren: 1'b0, addr: 10'd0, data: 4'd0, ack: 5'd0, busy: 1'b0, gid: 3'd0,
          err: err_m, ph: 0, rst: 1'b0};
    return e;
  endfunction

  task automatic model_step();
    exp_t e;
    int   w;
    granted = -1;
    if (reset) begin
      exp_q.delete();
      rr_m  = 0;
      gp_m  = 1;
      err_m = 1'b0;
      cur   = idle_entry();
      cur.rst = 1'b1;
      return;
    end
    if (exp_q.size() == 0 && req != 5'd0) begin
      w = pick();
      granted = w;
      e = idle_entry();
      e.busy = 1'b1;
      e.gid  = 3'(w);
      if (oa[w] != na[w]) begin
        if (!legal(oa[w])) err_m = 1'b1;
        e.wren = legal(oa[w]); e.addr = oa[w]; e.data = ot[w]; e.err = err_m; e.ph = 1;
        exp_q.push_back(e);
      end
      if (!legal(na[w])) err_m = 1'b1;
      e.wren = legal(na[w]); e.addr = na[w]; e.data = nt[w]; e.err = err_m; e.ph = 2;
      exp_q.push_back(e);
      e.wren = 1'b0; e.ack = 5'(32'd1 << w); e.ph = 3;
      exp_q.push_back(e);
      exp_q.push_back(idle_entry());
    end
    if (exp_q.size() > 0) cur = exp_q.pop_front();
    else cur = idle_entry();
  endtask

  task automatic compare();
    chk("wren", 32'(wren), 32'(cur.wren));
    chk("busy", 32'(busy), 32'(cur.busy));
    chk("ack",  32'(ack),  32'(cur.ack));
    chk("err",  32'(err),  32'(cur.err));
    if (cur.wren || cur.rst) begin
      chk("write_addr", 32'(write_addr), 32'(cur.addr));
      chk("write_data", 32'(write_data), 32'(cur.data));
    end
    if (cur.busy || cur.rst) chk("grant_id", 32'(grant_id), 32'(cur.gid));
  endtask

  task automatic update_stim();
    if (inj) begin
      reset = 1'b0;
      inj   = 1'b0;
    end else if (!reset && ((mid_arm && cur.ph == 2) ||
                            (rand_rst && cur.ph != 0 && $urandom_range(0, 63) == 0))) begin
      reset   = 1'b1;
      inj     = 1'b1;
      mid_arm = 1'b0;
    end
    if (granted >= 0) rand_ops(granted);
    for (int i = 0; i < N; i++) begin
      if (cur.ack[i]) begin
        if (hold[i]) rand_ops(i);
        else req[i] = 1'b0;
      end else if (!req[i] && rate > 0 && $urandom_range(0, 99) < rate) begin
        rand_ops(i);
        req[i] = 1'b1;
      end
    end
    pack();
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
      update_stim();
    end
  end

  task automatic sync();
    @(negedge clk);
    #1;
  endtask

  task automatic raise(input int i, input logic [9:0] a0, input logic [3:0] t0,
                       input logic [9:0] a1, input logic [3:0] t1);
    oa[i] = a0; ot[i] = t0; na[i] = a1; nt[i] = t1;
    req[i] = 1'b1;
    pack();
  endtask

  task automatic raise_rand(input int i);
    rand_ops(i);
    req[i] = 1'b1;
    pack();
  endtask

  function automatic logic is_idle();
    return req == 5'd0 && exp_q.size() == 0 && cur.ph == 0 && !inj && !mid_arm;
  endfunction

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!is_idle() && n < budget) begin
      sync();
      n++;
    end
    chk("idle_wait", 32'(is_idle()), 32'd1);
  endtask

  task automatic do_reset();
    sync();
    reset = 1'b1;
    sync();
    reset = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    reset = 1'b1; req = 5'd0; hold = 5'd0; rate = 0;
    rand_rst = 1'b0; mid_arm = 1'b0; inj = 1'b0;
    rr_m = 0; gp_m = 1; err_m = 1'b0; granted = -1;
    cur = idle_entry();
    for (int i = 0; i < N; i++) begin
      oa[i] = 10'd0; na[i] = 10'd0; ot[i] = 4'd0; nt[i] = 4'd0;
    end
    pack();
    repeat (3) sync();
    reset = 1'b0;
    sync();

    raise(0, 10'd40, 4'd0, 10'd41, 4'd3);
    wait_idle(40);
    raise(2, 10'd100, 4'd0, 10'd100, 4'd5);
    wait_idle(40);
    raise(1, 10'd50, 4'd7, 10'd800, 4'd2);
    wait_idle(40);

    do_reset();
    for (int i = 0; i < N; i++) raise_rand(i);
    wait_idle(100);

    hold = 5'h1F;
    for (int i = 0; i < N; i++) raise_rand(i);
    repeat (60) sync();
    hold = 5'h00;
    wait_idle(100);

    mid_arm = 1'b1;
    raise(3, 10'd200, 4'd1, 10'd201, 4'd2);
    wait_idle(60);

    hold = 5'b00001;
    raise_rand(0);
    raise_rand(2);
    repeat (40) sync();
    hold = 5'h00;
    wait_idle(100);

    rate = 25; rand_rst = 1'b1;
    repeat (3000) sync();
    hold = 5'b10110; rate = 20;
    repeat (1500) sync();
    hold = 5'h00; rate = 0; rand_rst = 1'b0;
    wait_idle(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
